// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline: opcode encodings and control-bus bit positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wisc_pkg;

   // Width of the decoder control bus and the all-zero value used for pipeline bubbles
   localparam int                CTRL_W      = 9;
   localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 9'b0;

   // Control-bus bit indices, MSB first: {MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,hlt,pcs,ALUOp,tophalf}
   localparam int CTRL_MEMREAD  = 8;
   localparam int CTRL_MEMTOREG = 7;
   localparam int CTRL_MEMWRITE = 6;
   localparam int CTRL_ALUSRC   = 5;
   localparam int CTRL_REGWRITE = 4;
   localparam int CTRL_HLT      = 3;
   localparam int CTRL_PCS      = 2;
   localparam int CTRL_ALUOP    = 1;
   localparam int CTRL_TOPHALF  = 0;

   // Opcode encodings (instruction[15:12])
   localparam logic [3:0] OPC_ADD    = 4'b0000;
   localparam logic [3:0] OPC_SUB    = 4'b0001;
   localparam logic [3:0] OPC_XOR    = 4'b0010;
   localparam logic [3:0] OPC_RED    = 4'b0011;
   localparam logic [3:0] OPC_SLL    = 4'b0100;
   localparam logic [3:0] OPC_SRA    = 4'b0101;
   localparam logic [3:0] OPC_ROR    = 4'b0110;
   localparam logic [3:0] OPC_PADDSB = 4'b0111;
   localparam logic [3:0] OPC_LW     = 4'b1000;
   localparam logic [3:0] OPC_SW     = 4'b1001;
   localparam logic [3:0] OPC_LLB    = 4'b1010;
   localparam logic [3:0] OPC_LHB    = 4'b1011;
   localparam logic [3:0] OPC_B      = 4'b1100;
   localparam logic [3:0] OPC_BR     = 4'b1101;
   localparam logic [3:0] OPC_PCS    = 4'b1110;
   localparam logic [3:0] OPC_HLT    = 4'b1111;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detector: which sources the ID instruction reads, and whether a load in EX feeds one.
// Latency: purely combinational.
// Backpressure: none; the result is consumed by the ID/EX register to decide stall vs capture.
// Ports: id_valid/id_opcode/id_rs/id_rt describe the ID instruction; ex_valid/ex_memread/ex_rd the EX one;
//        uses_rs/uses_rt/load_use are the decoded source usage and the hazard flag.
module hazard_detect
   import wisc_pkg::*;
#(
   parameter int RW = 4
) (
   input  logic          id_valid,
   input  logic [3:0]    id_opcode,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          ex_valid,
   input  logic          ex_memread,
   input  logic [RW-1:0] ex_rd,
   output logic          uses_rs,
   output logic          uses_rt,
   output logic          load_use
);

   // Everything up to LHB reads rs (LLB/LHB read their destination through rs); BR reads its target from rs.
   assign uses_rs = (id_opcode <= OPC_LHB) || (id_opcode == OPC_BR);

   // The three-register ALU ops and PADDSB read rt; SW reads its store data through rt.
   assign uses_rt = (id_opcode <= OPC_RED) || (id_opcode == OPC_PADDSB) || (id_opcode == OPC_SW);

   // R0 is hard-wired, so a load targeting it can never feed a consumer.
   assign load_use = id_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                     ((uses_rs && (ex_rd == id_rs)) || (uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, halt freeze and a stall counter.
// Latency: one cycle from id_* to ex_*; no combinational id_* -> ex_* path.
// Backpressure: stall_o (combinational) holds PC and IF/ID on a load-use hazard and forever once halted.
// Ports: clk/rst_n; id_* decoded instruction and operands in; flush_i squashes the ID instruction;
//        ex_* registered instruction out; stall_o, halted_o (sticky), stall_cnt_o (saturating load-use stalls).
module id_ex_stage
   import wisc_pkg::*;
#(
   parameter int DW    = 16,
   parameter int RW    = 4,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [3:0]        id_opcode,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [RW-1:0]     id_rs,
   input  logic [RW-1:0]     id_rt,
   input  logic [RW-1:0]     id_rd,
   input  logic [DW-1:0]     id_rs_data,
   input  logic [DW-1:0]     id_rt_data,
   input  logic [DW-1:0]     id_imm,
   input  logic [DW-1:0]     id_pc_plus2,
   input  logic              flush_i,
   output logic              ex_valid,
   output logic [3:0]        ex_opcode,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [RW-1:0]     ex_rs,
   output logic [RW-1:0]     ex_rt,
   output logic [RW-1:0]     ex_rd,
   output logic [DW-1:0]     ex_rs_data,
   output logic [DW-1:0]     ex_rt_data,
   output logic [DW-1:0]     ex_imm,
   output logic [DW-1:0]     ex_pc_plus2,
   output logic              stall_o,
   output logic              halted_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic             uses_rs;
   logic             uses_rt;
   logic             load_use;
   logic             halted_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             insert_bubble;

   hazard_detect #(.RW(RW)) u_hazard (
      .id_valid   (id_valid),
      .id_opcode  (id_opcode),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .ex_valid   (ex_valid),
      .ex_memread (ex_ctrl[CTRL_MEMREAD]),
      .ex_rd      (ex_rd),
      .uses_rs    (uses_rs),
      .uses_rt    (uses_rt),
      .load_use   (load_use)
   );

   // A flush already discards the ID instruction, so holding the front end for it would be wasted.
   assign stall_o       = halted_q || (load_use && !flush_i);
   assign insert_bubble = halted_q || flush_i || load_use;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_opcode   <= '0;
         ex_ctrl     <= CTRL_BUBBLE;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_rs_data  <= '0;
         ex_rt_data  <= '0;
         ex_imm      <= '0;
         ex_pc_plus2 <= '0;
         halted_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         // HLT completes its own EX cycle; the freeze takes effect from the following edge,
         // and a flush arriving alongside cannot undo it.
         if (ex_valid && ex_ctrl[CTRL_HLT])
            halted_q <= 1'b1;

         if (insert_bubble) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_ctrl     <= CTRL_BUBBLE;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_pc_plus2 <= '0;
         end else begin
            ex_valid    <= id_valid;
            ex_opcode   <= id_opcode;
            ex_ctrl     <= id_ctrl;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm      <= id_imm;
            ex_pc_plus2 <= id_pc_plus2;
         end

         // Only genuine load-use stalls are counted; halt and flush bubbles are not.
         if (!halted_q && !flush_i && load_use && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign halted_o    = halted_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   localparam logic [8:0] C_ADD = 9'b000010010;
   localparam logic [8:0] C_LW  = 9'b110110000;
   localparam logic [8:0] C_LLB = 9'b000110000;
   localparam logic [8:0] C_HLT = 9'b000001000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [3:0]  id_opcode = '0;
   logic [8:0]  id_ctrl = '0;
   logic [3:0]  id_rs = '0, id_rt = '0, id_rd = '0;
   logic [15:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, id_pc_plus2 = '0;
   logic        flush_i = 1'b0;
   logic        ex_valid;
   logic [3:0]  ex_opcode;
   logic [8:0]  ex_ctrl;
   logic [3:0]  ex_rs, ex_rt, ex_rd;
   logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus2;
   logic        stall_o, halted_o;
   logic [15:0] stall_cnt_o;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_ctrl(id_ctrl),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_pc_plus2(id_pc_plus2), .flush_i(flush_i),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_rd(ex_rd), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_pc_plus2(ex_pc_plus2), .stall_o(stall_o), .halted_o(halted_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   // Architectural view of the EX slot plus the expected stall for the cycle's inputs.
   typedef struct {
      logic        stall;
      logic        v;
      logic [3:0]  opc;
      logic [8:0]  ctrl;
      logic [3:0]  rs, rt, rd;
      logic [15:0] rsd, rtd, imm, pc;
      logic        halted;
      logic [15:0] cnt;
   } exp_t;

   exp_t m;          // model state after the most recent edge
   exp_t q[$];       // scoreboard
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t zero_state();
      exp_t z;
      z.stall = 0; z.v = 0; z.opc = 0; z.ctrl = 0; z.rs = 0; z.rt = 0; z.rd = 0;
      z.rsd = 0; z.rtd = 0; z.imm = 0; z.pc = 0; z.halted = 0; z.cnt = 0;
      return z;
   endfunction

   // Drive one cycle of ID inputs and predict the stall now and the EX contents after the next edge.
   task automatic issue(input logic v, input logic [3:0] opc, input logic [8:0] ctrl,
                        input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                        input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm,
                        input logic [15:0] pc, input logic fl);
      exp_t n;
      bit reads_rs, reads_rt, hazard;
      @(negedge clk);
      id_valid = v; id_opcode = opc; id_ctrl = ctrl; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_pc_plus2 = pc; flush_i = fl;
      reads_rs = opc inside {[4'd0:4'd11], 4'd13};
      reads_rt = opc inside {[4'd0:4'd3], 4'd7, 4'd9};
      hazard = v && m.v && m.ctrl[8] && (m.rd != 0) &&
               ((reads_rs && m.rd == rs) || (reads_rt && m.rd == rt));
      n = zero_state();
      n.stall  = m.halted || (hazard && !fl);
      n.halted = m.halted || (m.v && m.ctrl[3]);
      n.cnt    = m.cnt;
      if (!m.halted && !fl && hazard && m.cnt != 16'hFFFF) n.cnt = m.cnt + 1;
      if (!(m.halted || fl || hazard)) begin
         n.v = v; n.opc = opc; n.ctrl = ctrl; n.rs = rs; n.rt = rt; n.rd = rd;
         n.rsd = rsd; n.rtd = rtd; n.imm = imm; n.pc = pc;
      end
      q.push_back(n);
      m = n;
   endtask

   task automatic alu(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                      input logic [15:0] rsd, input logic fl);
      issue(1, 4'b0000, C_ADD, rs, rt, rd, rsd, 16'h0002, 16'h0, 16'h0100, fl);
   endtask

   task automatic lw(input logic [3:0] rd);
      issue(1, 4'b1000, C_LW, 4'd1, 4'd0, rd, 16'h0040, 16'h0, 16'h0004, 16'h0200, 0);
   endtask

   // Wait until the monitor has consumed every queued expectation.
   task automatic drain();
      int n = 0;
      @(posedge clk); #3;
      while (q.size() != 0 && n < 20) begin @(posedge clk); #3; n++; end
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
   endtask

   // Monitor: stall_o for the current inputs mid-cycle, registered outputs just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (q.size() != 0 && rst_n) begin
            e = q[0];
            chk("stall_o", stall_o, e.stall);
            @(posedge clk); #1;
            void'(q.pop_front());
            chk("ex_valid", ex_valid, e.v);
            chk("ex_opcode", ex_opcode, e.opc);
            chk("ex_ctrl", ex_ctrl, e.ctrl);
            chk("ex_rs", ex_rs, e.rs);
            chk("ex_rt", ex_rt, e.rt);
            chk("ex_rd", ex_rd, e.rd);
            chk("ex_rs_data", ex_rs_data, e.rsd);
            chk("ex_rt_data", ex_rt_data, e.rtd);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_pc_plus2", ex_pc_plus2, e.pc);
            chk("halted_o", halted_o, e.halted);
            chk("stall_cnt_o", stall_cnt_o, e.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t expected < 200000", $time);
      $fatal(1);
   end

   task automatic check_zero(input string tag);
      chk({tag, "_ex_valid"}, ex_valid, 0);
      chk({tag, "_ex_ctrl"}, ex_ctrl, 0);
      chk({tag, "_ex_rs_data"}, ex_rs_data, 0);
      chk({tag, "_ex_pc"}, ex_pc_plus2, 0);
      chk({tag, "_halted"}, halted_o, 0);
      chk({tag, "_cnt"}, stall_cnt_o, 0);
      chk({tag, "_stall"}, stall_o, 0);
   endtask

   initial begin
      m = zero_state();
      #12;
      check_zero("reset");
      @(negedge clk); rst_n = 1'b1;

      // ADD R1,R2,R3 captured in one cycle
      alu(4'd2, 4'd3, 4'd1, 16'd5, 0);
      @(posedge clk); #1;
      chk("add_ex_valid", ex_valid, 1);
      chk("add_ex_ctrl", ex_ctrl, C_ADD);
      chk("add_ex_rs_data", ex_rs_data, 16'd5);

      // LW R3 then ADD R4,R3,R2: one stall cycle, bubble, then capture
      lw(4'd3);
      alu(4'd3, 4'd2, 4'd4, 16'h0011, 0);
      #2 chk("lu_stall", stall_o, 1);
      @(posedge clk); #1 chk("lu_bubble", ex_valid, 0);
      alu(4'd3, 4'd2, 4'd4, 16'h0011, 0);
      #2 chk("lu_stall_drop", stall_o, 0);
      @(posedge clk); #1;
      chk("lu_capture_rd", ex_rd, 4'd4);
      chk("lu_cnt", stall_cnt_o, 16'd1);

      // R0 destination never hazards; LLB only reads rs
      lw(4'd0);
      alu(4'd0, 4'd0, 4'd4, 16'h0, 0);
      #2 chk("r0_no_stall", stall_o, 0);
      lw(4'd3);
      issue(1, 4'b1010, C_LLB, 4'd5, 4'd3, 4'd5, 16'h7, 16'h0, 16'h00AB, 16'h0300, 0);
      #2 chk("llb_no_stall", stall_o, 0);

      // flush beats load-use
      lw(4'd3);
      alu(4'd3, 4'd3, 4'd6, 16'h1, 1);
      #2 chk("flush_stall", stall_o, 0);
      @(posedge clk); #1;
      chk("flush_bubble", ex_valid, 0);
      chk("flush_cnt", stall_cnt_o, 16'd1);

      // randomized traffic, HLT excluded
      for (int i = 0; i < 1500; i++) begin
         logic [8:0] c;
         c = 9'($urandom) & ~C_HLT;
         if ($urandom_range(0, 2) == 0) c = C_LW;
         issue($urandom_range(0, 7) != 0, 4'($urandom_range(0, 14)), c,
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(0, 7) == 0);
      end

      // asynchronous reset mid-stream with a valid instruction in EX
      alu(4'd0, 4'd0, 4'd0, 16'hBEEF, 0);
      drain();
      chk("pre_reset_valid", ex_valid, 1);
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      m = zero_state();
      @(negedge clk); rst_n = 1'b1;

      // counter saturation
      drain();
      force dut.stall_cnt_q = 16'hFFFF;
      #1 release dut.stall_cnt_q;
      m.cnt = 16'hFFFF;
      #1 chk("cnt_forced", stall_cnt_o, 16'hFFFF);
      lw(4'd3);
      alu(4'd3, 4'd1, 4'd2, 16'h0, 0);
      #2 chk("sat_stall", stall_o, 1);
      @(posedge clk); #1 chk("sat_hold", stall_cnt_o, 16'hFFFF);

      // HLT in EX alongside a flush still halts; front end frozen afterwards
      issue(1, 4'b1111, C_HLT, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0400, 0);
      alu(4'd1, 4'd2, 4'd3, 16'h9, 1);
      @(posedge clk); #1 chk("halt_set", halted_o, 1);
      for (int i = 0; i < 4; i++) begin
         alu(4'd1, 4'd2, 4'd3, 16'h9, 0);
         #2 chk("halt_stall", stall_o, 1);
         @(posedge clk); #1 chk("halt_bubble", ex_valid, 0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
